program_fetch: RTL and testbench
================================

PROGRAM_FETCH -- requirements
Module: program_fetch

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 8: number of return-address entries; must be a power of two.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port Rom_addr_out, output, 11: program memory address; equal to the current PC.
REQ-005 SHALL have port Rom_data_in, input, 14: combinational instruction word returned for Rom_addr_out.
REQ-006 SHALL have port stall, input, 1: hold PC, IR and stack; ignore all redirect inputs.
REQ-007 SHALL have port flush, input, 1: replace the word being loaded into IR with NOP (skip).
REQ-008 SHALL have port jump_en, input, 1: load jump_addr into PC (GOTO).
REQ-009 SHALL have port jump_addr, input, 11: target for jump_en and call_en.
REQ-010 SHALL have port call_en, input, 1: push the return address and load jump_addr (CALL).
REQ-011 SHALL have port ret_en, input, 1: pop the stack into PC (RETURN/RETLW/RETFIE).
REQ-012 SHALL have port ir_out, output, 14: instruction register.
REQ-013 SHALL have port ir_valid, output, 1: ir_out holds a fetched word, not an injected NOP.
REQ-014 SHALL have port ir_pc, output, 11: address from which ir_out was fetched.
REQ-015 SHALL have port stack_overflow, output, 1: sticky flag, push while full.
REQ-016 SHALL have port stack_underflow, output, 1: sticky flag, pop while empty.

Function
REQ-017 SHALL drive Rom_addr_out combinationally from the PC register, with no added latency.
REQ-018 SHALL, on each edge with stall=0, load ir_out and ir_pc from Rom_data_in and the PC; fetch-to-IR latency is one cycle.
REQ-019 SHALL select next PC by priority ret_en > call_en > jump_en > increment when stall=0.
REQ-020 SHALL increment PC modulo 2^11, wrapping 0x7FF to 0x000.
REQ-021 SHALL, on call_en, push the current PC (already addressing the word after CALL) and set PC=jump_addr.
REQ-022 SHALL, on ret_en, set PC to the top-of-stack value and pop.
REQ-023 SHALL load NOP (14'h0000) into ir_out with ir_valid=0 on any edge where flush, jump_en, call_en or ret_en is 1; this gives a two-cycle branch.
REQ-024 SHALL, when stall=1, hold all registers and discard flush, jump_en, call_en and ret_en.
REQ-025 SHALL implement the stack as circular: a 3-bit (log2 STACK_DEPTH) pointer wraps, push-when-full overwrites the oldest entry, and pop-when-empty returns the wrapped entry.
REQ-026 SHALL keep an occupancy count saturating at 0..STACK_DEPTH; push at STACK_DEPTH sets stack_overflow, pop at 0 sets stack_underflow.
REQ-027 SHALL, when call_en and ret_en are both 1, perform the return only; no push occurs.

Reset
REQ-028 SHALL, on rst_n=0 regardless of clock, set PC=0, ir_out=NOP, ir_valid=0, ir_pc=0, stack pointer=0, count=0, all entries=0 and both flags=0.
REQ-029 SHALL fetch address 0x000 on the first edge after rst_n rises; reset mid-branch discards the redirect.
REQ-030 SHALL clear stack_overflow and stack_underflow only by reset.

Structure
REQ-031 SHALL take PC_W=11, INSTR_W=14, NOP_INSTR=14'h0000 and STACK_DEPTH from shared package pic_pkg.
REQ-032 SHALL place the circular stack, pointer, count and flags in sub-module pic_call_stack, with push, pop, din, dout, overflow and underflow ports.

Verification
REQ-033 SHALL test reset release with ROM words 0x01A5, 0x01A4, 0x01A3 at 0..2: Rom_addr_out = 0,1,2,3; ir_out = 0x01A5, 0x01A4, 0x01A3 with ir_valid=1; ir_pc = 0,1,2.
REQ-034 SHALL test jump_en=1 with jump_addr=0x007 while PC=0x00E: next Rom_addr_out=0x007, ir_out=NOP with ir_valid=0, then the word at 0x007.
REQ-035 SHALL test call_en with jump_addr=0x100 at PC=0x021, then ret_en: PC=0x100, later PC=0x021 again, count back to 0, no flags set.
REQ-036 SHALL test 9 calls with no returns: stack_overflow=1 after the ninth; 9 returns then yield the 8 newest addresses plus a wrapped entry, and stack_underflow=1.
REQ-037 SHALL test PC=0x7FF with no controls: next Rom_addr_out=0x000 and ir_pc=0x7FF.
REQ-038 SHALL test stall=1 held 3 cycles with jump_en=1: PC and ir_out unchanged and the jump ignored; flush=1 alone loads NOP with ir_valid=0 while PC increments.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared widths, constants and types for the
// program fetch unit and its call stack.
package pic_pkg;

   localparam int PC_W = 11;
   localparam int INSTR_W = 14;
   localparam int STACK_DEPTH = 8;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 14'h0000;

   typedef enum logic [1:0] {
      SEL_INC,
      SEL_JMP,
      SEL_RET
   } pc_sel_e;

endpackage

// File: rtl/pic_call_stack.sv
// Circular return-address stack with saturating
// occupancy count and sticky overflow/underflow.
module pic_call_stack
   import pic_pkg::*;
#(
   parameter int DEPTH = STACK_DEPTH
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [PC_W-1:0] din,
   output logic [PC_W-1:0] dout,
   output logic            overflow,
   output logic            underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PC_W-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] top;
   logic [CNT_W-1:0] count;

   assign top  = ptr - PTR_W'(1);
   assign dout = mem[top];

   // Pointer wraps freely; pop wins if both are requested.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (pop) begin
         ptr <= top;
         if (count == '0) begin
            underflow <= 1'b1;
         end else begin
            count <= count - CNT_W'(1);
         end
      end else if (push) begin
         mem[ptr] <= din;
         ptr      <= ptr + PTR_W'(1);
         if (count == CNT_W'(DEPTH)) begin
            overflow <= 1'b1;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/program_fetch.sv
// PC, instruction register and redirect handling
// for a PIC-style two-cycle fetch pipeline.
module program_fetch
   import pic_pkg::*;
#(
   parameter int STACK_DEPTH = pic_pkg::STACK_DEPTH
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [PC_W-1:0]    Rom_addr_out,
   input  logic [INSTR_W-1:0] Rom_data_in,
   input  logic               stall,
   input  logic               flush,
   input  logic               jump_en,
   input  logic [PC_W-1:0]    jump_addr,
   input  logic               call_en,
   input  logic               ret_en,
   output logic [INSTR_W-1:0] ir_out,
   output logic               ir_valid,
   output logic [PC_W-1:0]    ir_pc,
   output logic               stack_overflow,
   output logic               stack_underflow
);

   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] stk_top;
   logic            redirect;
   logic            push;
   logic            pop;
   pc_sel_e         sel;

   assign Rom_addr_out = pc;
   assign redirect = flush | jump_en | call_en | ret_en;
   assign pop  = ~stall & ret_en;
   assign push = ~stall & call_en & ~ret_en;

   // Next-PC source: return beats call beats jump.
   always_comb begin
      sel = SEL_INC;
      priority case (1'b1)
         ret_en:  sel = SEL_RET;
         call_en: sel = SEL_JMP;
         jump_en: sel = SEL_JMP;
         default: sel = SEL_INC;
      endcase
   end

   // Mux the selected next-PC value.
   always_comb begin
      pc_next = pc + PC_W'(1);
      case (sel)
         SEL_RET: pc_next = stk_top;
         SEL_JMP: pc_next = jump_addr;
         default: pc_next = pc + PC_W'(1);
      endcase
   end

   // PC and IR advance together unless stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= '0;
         ir_out   <= NOP_INSTR;
         ir_valid <= 1'b0;
         ir_pc    <= '0;
      end else if (!stall) begin
         pc    <= pc_next;
         ir_pc <= pc;
         if (redirect) begin
            ir_out   <= NOP_INSTR;
            ir_valid <= 1'b0;
         end else begin
            ir_out   <= Rom_data_in;
            ir_valid <= 1'b1;
         end
      end
   end

   pic_call_stack #(
      .DEPTH(STACK_DEPTH)
   ) u_stack (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .din      (pc),
      .dout     (stk_top),
      .overflow (stack_overflow),
      .underflow(stack_underflow)
   );

endmodule

// File: tb/tb_program_fetch.sv
// Scoreboard bench for program_fetch: a
// reference model queues expectations per edge.
module tb_program_fetch;
   import pic_pkg::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [PC_W-1:0]    Rom_addr_out;
   logic [INSTR_W-1:0] Rom_data_in;
   logic               stall, flush, jump_en, call_en, ret_en;
   logic [PC_W-1:0]    jump_addr;
   logic [INSTR_W-1:0] ir_out;
   logic               ir_valid;
   logic [PC_W-1:0]    ir_pc;
   logic               stack_overflow, stack_underflow;

   int n_run = 0;
   int n_fail = 0;

   typedef struct {
      logic [10:0] pc;
      logic [13:0] ir;
      logic        vld;
      logic [10:0] irpc;
      logic        ovf;
      logic        udf;
      logic [3:0]  cnt;
   } exp_t;

   exp_t sb[$];

   logic [10:0] m_pc, m_irpc;
   logic [13:0] m_ir;
   logic        m_vld, m_ovf, m_udf;
   logic [10:0] m_stk [8];
   int          m_ptr, m_cnt;

   always #5 clk = ~clk;

   function automatic logic [13:0] romf(input logic [10:0] a);
      return 14'(14'h1A5 - {3'b000, a});
   endfunction

   assign Rom_data_in = romf(Rom_addr_out);

   program_fetch #(.STACK_DEPTH(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .Rom_addr_out   (Rom_addr_out),
      .Rom_data_in    (Rom_data_in),
      .stall          (stall),
      .flush          (flush),
      .jump_en        (jump_en),
      .jump_addr      (jump_addr),
      .call_en        (call_en),
      .ret_en         (ret_en),
      .ir_out         (ir_out),
      .ir_valid       (ir_valid),
      .ir_pc          (ir_pc),
      .stack_overflow (stack_overflow),
      .stack_underflow(stack_underflow)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      m_pc = '0; m_irpc = '0; m_ir = '0; m_vld = 1'b0;
      m_ovf = 1'b0; m_udf = 1'b0; m_ptr = 0; m_cnt = 0;
      for (int i = 0; i < 8; i++) m_stk[i] = '0;
   endtask

   task automatic step(input logic s, input logic f, input logic j,
                       input logic c, input logic r,
                       input logic [10:0] a);
      exp_t e;
      logic rd;
      stall = s; flush = f; jump_en = j;
      call_en = c; ret_en = r; jump_addr = a;
      rd = f | j | c | r;
      if (!s) begin
         m_ir   = rd ? 14'h0000 : romf(m_pc);
         m_vld  = !rd;
         m_irpc = m_pc;
         if (r) begin
            m_ptr = (m_ptr + 7) % 8;
            if (m_cnt == 0) m_udf = 1'b1;
            else m_cnt--;
            m_pc = m_stk[m_ptr];
         end else if (c) begin
            m_stk[m_ptr] = m_pc;
            m_ptr = (m_ptr + 1) % 8;
            if (m_cnt == 8) m_ovf = 1'b1;
            else m_cnt++;
            m_pc = a;
         end else if (j) begin
            m_pc = a;
         end else begin
            m_pc = m_pc + 11'd1;
         end
      end
      e.pc = m_pc; e.ir = m_ir; e.vld = m_vld; e.irpc = m_irpc;
      e.ovf = m_ovf; e.udf = m_udf; e.cnt = 4'(m_cnt);
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("sb_pc", Rom_addr_out, e.pc);
      chk("sb_ir", ir_out, e.ir);
      chk("sb_vld", ir_valid, e.vld);
      chk("sb_irpc", ir_pc, e.irpc);
      chk("sb_ovf", stack_overflow, e.ovf);
      chk("sb_udf", stack_underflow, e.udf);
      chk("sb_cnt", dut.u_stack.count, e.cnt);
   endtask

   initial begin
      rst_n = 1'b0;
      stall = 0; flush = 0; jump_en = 0;
      call_en = 0; ret_en = 0; jump_addr = '0;
      m_reset();
      #12;
      chk("rst_pc", Rom_addr_out, 0);
      chk("rst_ir", ir_out, 0);
      chk("rst_vld", ir_valid, 0);
      chk("rst_irpc", ir_pc, 0);
      chk("rst_ovf", stack_overflow, 0);
      chk("rst_udf", stack_underflow, 0);
      #11;
      rst_n = 1'b1;
      chk("rel_addr", Rom_addr_out, 0);

      // fetch after reset release
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 0);
         chk("fetch_addr", Rom_addr_out, i + 1);
         chk("fetch_ir", ir_out, 14'h1A5 - i);
         chk("fetch_vld", ir_valid, 1);
         chk("fetch_irpc", ir_pc, i);
      end

      // goto
      step(0, 0, 1, 0, 0, 11'h00E);
      step(0, 0, 1, 0, 0, 11'h007);
      chk("jmp_addr", Rom_addr_out, 11'h007);
      chk("jmp_nop", ir_out, 14'h0000);
      chk("jmp_vld", ir_valid, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("jmp_ir", ir_out, 14'h19E);
      chk("jmp_irpc", ir_pc, 11'h007);
      chk("jmp_vld2", ir_valid, 1);

      // call / return
      step(0, 0, 1, 0, 0, 11'h021);
      step(0, 0, 0, 1, 0, 11'h100);
      chk("call_pc", Rom_addr_out, 11'h100);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("ret_pc", Rom_addr_out, 11'h021);
      chk("ret_cnt", dut.u_stack.count, 0);
      chk("ret_ovf", stack_overflow, 0);
      chk("ret_udf", stack_underflow, 0);

      // call and return together: return only
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 11'h300);
      chk("cr_cnt", dut.u_stack.count, 0);
      chk("cr_udf", stack_underflow, 1);

      // PC wrap
      step(0, 0, 1, 0, 0, 11'h7FF);
      step(0, 0, 0, 0, 0, 0);
      chk("wrap_addr", Rom_addr_out, 0);
      chk("wrap_irpc", ir_pc, 11'h7FF);

      // stall with jump, then flush
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 1, 0, 0, 11'h055);
         chk("stall_addr", Rom_addr_out, 1);
         chk("stall_ir", ir_out, 14'h1A5);
      end
      step(0, 1, 0, 0, 0, 0);
      chk("flush_ir", ir_out, 0);
      chk("flush_vld", ir_valid, 0);
      chk("flush_addr", Rom_addr_out, 2);

      // reset mid-branch
      jump_en = 1'b1;
      jump_addr = 11'h055;
      rst_n = 1'b0;
      #1;
      chk("arst_pc", Rom_addr_out, 0);
      chk("arst_udf", stack_underflow, 0);
      m_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step(0, 0, 0, 0, 0, 0);
      chk("rel2_addr", Rom_addr_out, 1);
      chk("rel2_ir", ir_out, 14'h1A5);
      chk("rel2_irpc", ir_pc, 0);

      // nine calls overflow, nine returns underflow
      for (int i = 0; i < 9; i++) begin
         step(0, 0, 0, 1, 0, 11'(32'h200 + 16 * i));
         chk("ovf_flag", stack_overflow, i == 8);
      end
      for (int i = 0; i < 9; i++) begin
         step(0, 0, 0, 0, 1, 0);
         chk("pop_pc", Rom_addr_out,
             (i < 8) ? 32'h270 - 16 * i : 32'h270);
         chk("udf_flag", stack_underflow, i == 8);
      end
      chk("ovf_sticky", stack_overflow, 1);
      chk("sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
